// File: rtl/fir_result_tx_if.sv
// Result-path bundle between the fir core, fir_result_tx and the host-side pin mux.
// slave = the transmitter block, master = the environment driving words and acks.
interface fir_result_tx_if #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [OUT_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_req;
    logic             tx_ack;
    logic [LW-1:0]    fifo_level;
    logic             busy;

    modport master (
        output in_data, in_valid, tx_ack,
        input  in_ready, tx_data, tx_last, tx_req, fifo_level, busy
    );

    modport slave (
        input  in_data, in_valid, tx_ack,
        output in_ready, tx_data, tx_last, tx_req, fifo_level, busy
    );
endinterface

// File: rtl/fir_result_tx.sv
// FIFO-buffered FIR result transmitter: each word goes out MSB byte first, one four-phase
// req/ack per byte. Define FIR_TX_ACK_SYNC_EN to pass tx_ack through a 2-flop synchronizer.
module fir_result_tx #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fir_result_tx_if.slave bus
);
    localparam int NB = OUT_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [OUT_W-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_tx_data;
    logic             r_tx_last;
    logic             r_tx_req;
    logic             r_busy;

    logic             w_ack_s;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_adv;
    logic [OUT_W-1:0] w_head;
    logic [OUT_W-1:0] w_shift_next;

`ifdef FIR_TX_ACK_SYNC_EN
    logic r_ack_meta;
    logic r_ack_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= bus.tx_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack_s = r_ack_sync;
`else
    assign w_ack_s = bus.tx_ack;
`endif

    // No bypass: a full FIFO refuses input even on the edge that pops it.
    assign w_in_ready   = (r_level != LW'(DEPTH));
    assign w_push       = bus.in_valid & w_in_ready;
    assign w_pop        = (r_state == IDLE) && (r_level != '0);
    assign w_adv        = (r_state == REL) && !w_ack_s && (r_cnt != '0);
    assign w_head       = r_mem[r_rptr];
    assign w_shift_next = r_shift << 8;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Shifter keeps the word being sent; the next byte is always the MSB after a shift.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_head;
        end else if (w_adv) begin
            r_shift <= w_shift_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_data <= '0;
            r_tx_last <= 1'b0;
            r_tx_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_head[OUT_W-1 -: 8];
                        r_tx_last <= (NB == 1);
                        r_tx_req  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= CW'(NB - 1);
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_tx_req <= 1'b0;
                        r_state  <= REL;
                    end
                end
                REL: begin
                    if (!w_ack_s) begin
                        if (r_cnt == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_tx_data <= w_shift_next[OUT_W-1 -: 8];
                            r_tx_last <= (r_cnt == CW'(1));
                            r_tx_req  <= 1'b1;
                            r_cnt     <= r_cnt - CW'(1);
                            r_state   <= REQ;
                        end
                    end
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_last    = r_tx_last;
    assign bus.tx_req     = r_tx_req;
    assign bus.fifo_level = r_level;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_fir_result_tx.sv
// Bench for fir_result_tx: word-queue/byte-list reference model compared every cycle,
// plus a host agent whose received byte stream is scoreboarded against the pushed words.
module tb_fir_result_tx;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;
    localparam int NB    = OUT_W / 8;
`ifdef FIR_TX_ACK_SYNC_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fir_result_tx_if #(.OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    fir_result_tx #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued words, bytes left of the word on the wire, and wire state.
    logic [OUT_W-1:0] m_q[$];
    logic [7:0]       m_bytes[$];
    logic [7:0]       m_data;
    bit               m_last, m_req, m_busy, m_s1, m_s2;
    logic [8:0]       sb[$];
    logic [8:0]       cap[$];

    bit h_en, h_rand;
    int h_ack_d, h_rel_d, h_cnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_bytes.delete();
        sb.delete();
        m_data = '0;
        m_last = 0;
        m_req  = 0;
        m_busy = 0;
        m_s1   = 0;
        m_s2   = 0;
    endtask

    task automatic next_byte();
        m_data = m_bytes.pop_front();
        m_last = (m_bytes.size() == 0);
        m_req  = 1;
    endtask

    task automatic model_step();
        bit ack, push;
        logic [OUT_W-1:0] w;
`ifdef FIR_TX_ACK_SYNC_EN
        ack  = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.tx_ack;
`else
        ack = bus.tx_ack;
`endif
        push = bus.in_valid && (m_q.size() != DEPTH);
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_bytes.delete();
                for (int b = NB - 1; b >= 0; b--) m_bytes.push_back(w[b*8 +: 8]);
                m_busy = 1;
                next_byte();
            end
        end else if (m_req) begin
            if (ack) m_req = 0;
        end else if (!ack) begin
            if (m_bytes.size() == 0) m_busy = 0;
            else next_byte();
        end
        if (push) begin
            m_q.push_back(bus.in_data);
            for (int b = NB - 1; b >= 0; b--) sb.push_back({(b == 0), bus.in_data[b*8 +: 8]});
        end
    endtask

    task automatic compare();
        check("tx_req", 32'(bus.tx_req), 32'(m_req));
        check("tx_data", 32'(bus.tx_data), 32'(m_data));
        check("tx_last", 32'(bus.tx_last), 32'(m_last));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("fifo_level", 32'(bus.fifo_level), 32'(m_q.size()));
        check("in_ready", 32'(bus.in_ready), 32'(m_q.size() != DEPTH));
    endtask

    task automatic take_byte();
        logic [8:0] got;
        got = {bus.tx_last, bus.tx_data};
        cap.push_back(got);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL host_byte: got %0h expected no byte at %0t", got, $time);
        end else begin
            check("host_byte", 32'(got), 32'(sb.pop_front()));
        end
    endtask

    task automatic host();
        if (!h_en) return;
        if (!bus.tx_ack) begin
            if (bus.tx_req) begin
                if (h_cnt <= 0) begin
                    take_byte();
                    bus.tx_ack = 1'b1;
                    h_cnt = h_rand ? int'($urandom_range(0, 3)) : h_rel_d;
                end else h_cnt--;
            end
        end else if (!bus.tx_req) begin
            if (h_cnt <= 0) begin
                bus.tx_ack = 1'b0;
                h_cnt = h_rand ? int'($urandom_range(0, 3)) : h_ack_d;
            end else h_cnt--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare();
        host();
    endtask

    task automatic push(logic [OUT_W-1:0] w, int budget);
        bit ok, rdy;
        ok = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %0h not taken in %0d cycles", w, budget);
        end
    endtask

    task automatic wait_idle(int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!m_busy && m_q.size() == 0 && sb.size() == 0 && !bus.tx_ack) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: traffic not drained in %0d cycles", budget);
        end
    endtask

    task automatic wait_req(int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.tx_req) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: tx_req not raised in %0d cycles", budget);
        end
    endtask

    function automatic logic [8:0] cap_at(int i);
        return (i < cap.size()) ? cap[i] : 9'h1FF;
    endfunction

    task automatic check_reset_outputs(string tag);
        check({tag, "_tx_req"}, 32'(bus.tx_req), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_tx_last"}, 32'(bus.tx_last), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        model_reset();
        bus.tx_ack   = 1'b0;
        bus.in_valid = 1'b0;
        h_en = 0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.tx_ack   = 1'b0;
        h_en = 0; h_rand = 0; h_cnt = 0; h_ack_d = 2; h_rel_d = 2;
        model_reset();

        // Power-on reset and quiet idle afterwards
        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (4) tick();
        check("idle_no_req", 32'(bus.tx_req), 32'd0);

        // Single word, fixed host delays
        h_en = 1; h_rand = 0; h_ack_d = 2; h_rel_d = 2; h_cnt = 2;
        cap.delete();
        push(16'hA55A, 10);
        wait_idle(200);
        check("a55a_count", 32'(cap.size()), 32'd2);
        check("a55a_byte0", 32'(cap_at(0)), 32'h0A5);
        check("a55a_byte1", 32'(cap_at(1)), 32'h15A);
        check("a55a_busy", 32'(bus.busy), 32'd0);

        // Back-pressure: host silent, six words offered back to back
        h_en = 0;
        cap.delete();
        for (int k = 1; k <= 5; k++) push(16'(k), 1);
        check("bp_level_full", 32'(bus.fifo_level), 32'd4);
        check("bp_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_data  = 16'h0006;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("bp_level_held", 32'(bus.fifo_level), 32'd4);
        check("bp_ready_held", 32'(bus.in_ready), 32'd0);
        h_en = 1; h_cnt = 1;
        n = 0;
        while (bus.fifo_level == 4 && n < 100) begin
            tick();
            n++;
        end
        check("pop_edge_level", 32'(bus.fifo_level), 32'd3);
        check("pop_edge_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("refill_level", 32'(bus.fifo_level), 32'd4);
        wait_idle(1000);
        check("bp_count", 32'(cap.size()), 32'd12);
        for (int k = 0; k < 6; k++) begin
            check("bp_msb", 32'(cap_at(2*k)), 32'h000);
            check("bp_lsb", 32'(cap_at(2*k+1)), 32'h100 | 32'(k + 1));
        end

        // Ack-to-req-drop latency
        h_en = 0;
        push(16'hC33C, 5);
        wait_req(10);
        take_byte();
        bus.tx_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (!bus.tx_req) break;
        end
        check("ack_latency", 32'(n), 32'(EXP_LAT));
        h_en = 1; h_cnt = 0;
        wait_idle(200);

        // Reset while the MSB byte of 0x1234 is requested
        h_en = 0;
        push(16'h1234, 5);
        wait_req(10);
        check("pre_rst_byte", 32'(bus.tx_data), 32'h12);
        async_reset();
        tick();
        h_en = 1; h_rand = 0; h_cnt = 1;
        cap.delete();
        push(16'hBEEF, 5);
        wait_idle(200);
        check("beef_count", 32'(cap.size()), 32'd2);
        check("beef_byte0", 32'(cap_at(0)), 32'h0BE);
        check("beef_byte1", 32'(cap_at(1)), 32'h1EF);

        // Randomised traffic with random host timing
        h_rand = 1; h_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            push(16'($urandom), 200);
        end
        wait_idle(3000);

        // Reset in the middle of random traffic
        for (int k = 0; k < 4; k++) push(16'($urandom), 200);
        repeat ($urandom_range(1, 6)) tick();
        async_reset();
        repeat (5) tick();
        check("post_rst_no_req", 32'(bus.tx_req), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
